// File: rtl/bus_group_pkg.sv
// Shared types and helpers for the bus group arbiter.
// Optional feature macro used by the top: BUS_GROUP_ARB_TIMEOUT_EN.
package bus_group_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    // Widest requester set the helpers below handle.
    localparam int MAX_MST = 8;

    // Data returned to the requester when the downstream never answers.
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // One-hot to binary index; an all-zero vector maps to 0.
    function automatic logic [2:0] oh2idx(input logic [MAX_MST-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MST; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_group_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around, so the requester at ptr gets the lowest priority.
module bus_group_rr_pick #(
    parameter  int N_MST = 4,
    localparam int PW    = $clog2(N_MST)
) (
    input  logic [N_MST-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_MST-1:0] grant,
    output logic             any
);

    logic [PW-1:0] idx;

    // Walk ptr+1 .. ptr+N_MST (mod N_MST) and keep the first hit.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_MST; i++) begin
            idx = PW'((int'(ptr) + i) % N_MST);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_group_arbiter.sv
// Round-robin arbiter sharing one downstream request/response channel among
// N_MST requesters. Grant is held from acceptance until the response pulse.
// Optional feature macro: BUS_GROUP_ARB_TIMEOUT_EN adds a response timeout
// and the o_timeout port.
module bus_group_arbiter
    import bus_group_pkg::*;
#(
    parameter int             N_MST     = 4,
    parameter int             DW        = 32,
    parameter int             TO_CYCLES = 256,
    parameter logic [DW-1:0]  ERR_DATA  = DW'(ERR_DATA_DEF)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_MST-1:0]    i_m_valid,
    output logic [N_MST-1:0]    o_m_ready,
    input  logic [N_MST*DW-1:0] i_m_data,
    output logic [DW-1:0]       o_m_data,
    output logic [N_MST-1:0]    o_m_resp,
    output logic                o_s_valid,
    input  logic                i_s_ready,
    output logic [DW-1:0]       o_s_data,
    input  logic [DW-1:0]       i_s_data,
    input  logic                i_s_resp,
    output logic [N_MST-1:0]    o_grant,
    output logic                o_busy
`ifdef BUS_GROUP_ARB_TIMEOUT_EN
    ,
    output logic                o_timeout
`endif
);

    localparam int PW = $clog2(N_MST);

    state_e            state, state_nxt;
    logic [N_MST-1:0]  grant_q, grant_nxt;
    logic [PW-1:0]     ptr_q, ptr_nxt;
    logic [DW-1:0]     hold_q, hold_nxt;
    logic [N_MST-1:0]  pick_oh;
    logic              pick_any;
    logic [DW-1:0]     req_mux;
    logic              to_hit;

    bus_group_rr_pick #(.N_MST(N_MST)) u_pick (
        .req   (i_m_valid),
        .ptr   (ptr_q),
        .grant (pick_oh),
        .any   (pick_any)
    );

    // AND-OR mux of the granted requester's data (grant is one-hot or zero).
    always_comb begin
        req_mux = '0;
        for (int k = 0; k < N_MST; k++) begin
            if (grant_q[k]) req_mux = req_mux | i_m_data[k*DW +: DW];
        end
    end

`ifdef BUS_GROUP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES) + 1;

    logic [CW-1:0] to_cnt;

    // Cycles spent in WAIT_RSP; cleared on the handshake that enters it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if (state == REQ && i_s_ready) begin
            to_cnt <= '0;
        end else if (state == WAIT_RSP) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A real response in the expiry cycle takes precedence over the timeout.
    assign to_hit    = (state == WAIT_RSP) && !i_s_resp && (to_cnt == CW'(TO_CYCLES - 1));
    assign o_timeout = to_hit;
`else
    // Feature compiled out: WAIT_RSP never expires. TO_CYCLES is only
    // referenced so the same parameter set elaborates in both builds.
    assign to_hit = (TO_CYCLES < 0);
`endif

    // State, grant, rr pointer and held response data registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(N_MST - 1);
            hold_q  <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            ptr_q   <= ptr_nxt;
            hold_q  <= hold_nxt;
        end
    end

    // Next-state logic and combinational channel outputs.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        ptr_nxt   = ptr_q;
        hold_nxt  = hold_q;
        o_s_valid = 1'b0;
        o_s_data  = '0;
        o_m_ready = '0;
        o_m_resp  = '0;
        o_m_data  = hold_q;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_oh;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // A response pulse here is ignored: it must arrive in WAIT_RSP.
                o_s_valid = 1'b1;
                o_s_data  = req_mux;
                o_m_ready = grant_q & {N_MST{i_s_ready}};
                if (i_s_ready) state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (i_s_resp || to_hit) begin
                    o_m_resp  = grant_q;
                    o_m_data  = i_s_resp ? i_s_data : ERR_DATA;
                    hold_nxt  = o_m_data;
                    ptr_nxt   = PW'(oh2idx(MAX_MST'(grant_q)));
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_grant = grant_q;
    assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_bus_group_arbiter.sv
// Directed + randomized bench for bus_group_arbiter against a round-robin
// reference model (last-served index, wrap-around search).
module tb_bus_group_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_m_valid;
    logic [N-1:0]      o_m_ready;
    logic [N*DW-1:0]   i_m_data;
    logic [DW-1:0]     o_m_data;
    logic [N-1:0]      o_m_resp;
    logic              o_s_valid;
    logic              i_s_ready;
    logic [DW-1:0]     o_s_data;
    logic [DW-1:0]     i_s_data;
    logic              i_s_resp;
    logic [N-1:0]      o_grant;
    logic              o_busy;
`ifdef BUS_GROUP_ARB_TIMEOUT_EN
    logic              o_timeout;
`endif

    always #5 i_clk = ~i_clk;

    bus_group_arbiter #(.N_MST(N), .DW(DW), .TO_CYCLES(TO)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_m_valid (i_m_valid),
        .o_m_ready (o_m_ready),
        .i_m_data  (i_m_data),
        .o_m_data  (o_m_data),
        .o_m_resp  (o_m_resp),
        .o_s_valid (o_s_valid),
        .i_s_ready (i_s_ready),
        .o_s_data  (o_s_data),
        .i_s_data  (i_s_data),
        .i_s_resp  (i_s_resp),
        .o_grant   (o_grant),
        .o_busy    (o_busy)
`ifdef BUS_GROUP_ARB_TIMEOUT_EN
        ,
        .o_timeout (o_timeout)
`endif
    );

    int            tests = 0;
    int            fails = 0;
    int            last;
    logic [DW-1:0] hold;
    logic [DW-1:0] mdat [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pack_data();
        for (int k = 0; k < N; k++) i_m_data[k*DW +: DW] = mdat[k];
    endtask

    // Reference arbitration: first valid requester after the last served one.
    function automatic int model_pick(input logic [N-1:0] v, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (v[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        i_m_valid = '0; i_s_ready = 1'b0; i_s_resp = 1'b0; i_s_data = '0;
        step();
        step();
        i_rst = 1'b0;
        last = N - 1;
        hold = '0;
    endtask

    // One full transaction starting in IDLE. rsp_dly = WAIT_RSP cycles before
    // the response; no_resp lets the timeout fire instead.
    task automatic do_txn(input logic [N-1:0] v, input int rdy_dly, input int rsp_dly,
                          input logic [DW-1:0] rsp, input bit no_resp, input bit spur_req);
        int g;
        logic [N-1:0] oh;
        i_m_valid = v; pack_data();
        i_s_ready = 1'b0; i_s_resp = 1'b0;
        #1;
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_grant", 32'(o_grant), 0);
        g  = model_pick(v, last);
        oh = '0;
        oh[g] = 1'b1;
        step();
        chk("req_grant", 32'(o_grant), 32'(oh));
        chk("req_svalid", 32'(o_s_valid), 1);
        chk("req_sdata", o_s_data, mdat[g]);
        for (int d = 0; d < rdy_dly; d++) begin
            chk("stall_mready", 32'(o_m_ready), 0);
            chk("stall_svalid", 32'(o_s_valid), 1);
            chk("stall_sdata", o_s_data, mdat[g]);
            step();
        end
        chk("hs_grant", 32'(o_grant), 32'(oh));
        i_s_ready = 1'b1;
        if (spur_req) begin
            i_s_resp = 1'b1;
            i_s_data = $urandom;
        end
        #1;
        chk("hs_mready", 32'(o_m_ready), 32'(oh));
        if (spur_req) begin
            chk("spur_req_resp", 32'(o_m_resp), 0);
            chk("spur_req_mdata", o_m_data, hold);
        end
        step();
        i_s_ready = 1'b0; i_s_resp = 1'b0;
        for (int c = 0; c < rsp_dly; c++) begin
            #1;
            chk("wait_resp", 32'(o_m_resp), 0);
            chk("wait_svalid", 32'(o_s_valid), 0);
            chk("wait_mdata", o_m_data, hold);
`ifdef BUS_GROUP_ARB_TIMEOUT_EN
            chk("wait_timeout", 32'(o_timeout), 0);
`endif
            step();
        end
        if (no_resp) begin
            #1;
            chk("to_resp", 32'(o_m_resp), 32'(oh));
            chk("to_mdata", o_m_data, 32'hDEAD_BEEF);
`ifdef BUS_GROUP_ARB_TIMEOUT_EN
            chk("to_pulse", 32'(o_timeout), 1);
`endif
            step();
            hold = 32'hDEAD_BEEF;
        end else begin
            i_s_resp = 1'b1; i_s_data = rsp;
            #1;
            chk("rsp_resp", 32'(o_m_resp), 32'(oh));
            chk("rsp_mdata", o_m_data, rsp);
`ifdef BUS_GROUP_ARB_TIMEOUT_EN
            chk("rsp_timeout", 32'(o_timeout), 0);
`endif
            step();
            i_s_resp = 1'b0;
            hold = rsp;
        end
        last = g;
        #1;
        chk("end_grant", 32'(o_grant), 0);
        chk("end_busy", 32'(o_busy), 0);
        chk("end_mdata", o_m_data, hold);
        chk("end_resp", 32'(o_m_resp), 0);
    endtask

    // Granted requester must keep valid up while the request is offered.
    always @(negedge i_clk) begin
        if (!i_rst && o_s_valid) begin
            assert ((i_m_valid & o_grant) != '0) else begin
                fails++;
                $error("FAIL proto_valid_drop observed=%b expected_grant=%b", i_m_valid, o_grant);
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) mdat[k] = '0;
        i_m_data = '0;
        do_reset();
        i_rst = 1'b1;
        #1;
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_svalid", 32'(o_s_valid), 0);
        chk("rst_mready", 32'(o_m_ready), 0);
        chk("rst_mresp", 32'(o_m_resp), 0);
        chk("rst_mdata", o_m_data, 0);
        step();
        i_rst = 1'b0;

        // Requester 2 alone, response two cycles after the handshake.
        mdat[2] = 32'h0000_1234;
        do_txn(4'b0100, 0, 1, 32'hA5A5_0002, 1'b0, 1'b0);

        // All four valid, immediate responses: 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < N; k++) mdat[k] = 32'h1000_0000 + 32'(k);
        for (int t = 0; t < 5; t++) begin
            do_txn(4'b1111, 0, 0, 32'hB000_0000 + 32'(t), 1'b0, 1'b0);
            chk("rr_order", 32'(last), 32'(t % N));
        end

        // Downstream stalls five cycles in REQ.
        mdat[1] = 32'hCAFE_0001;
        do_txn(4'b0010, 5, 2, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Spurious response in IDLE, then one during the REQ handshake.
        i_m_valid = '0; i_s_resp = 1'b1; i_s_data = 32'h5555_AAAA;
        #1;
        chk("spur_idle_resp", 32'(o_m_resp), 0);
        chk("spur_idle_mdata", o_m_data, hold);
        step();
        i_s_resp = 1'b0;
        chk("spur_idle_busy", 32'(o_busy), 0);
        do_txn(4'b1000, 1, 0, 32'h7777_0003, 1'b0, 1'b1);

        // Reset while waiting for a response; the late response is ignored.
        i_m_valid = 4'b0010; mdat[1] = 32'h1111_2222; pack_data();
        step();
        i_s_ready = 1'b1;
        step();
        i_s_ready = 1'b0;
        chk("pre_rst_busy", 32'(o_busy), 1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0; last = N - 1; hold = '0;
        i_s_resp = 1'b1; i_s_data = 32'h9999_9999; i_m_valid = '0;
        #1;
        chk("mrst_resp", 32'(o_m_resp), 0);
        chk("mrst_grant", 32'(o_grant), 0);
        chk("mrst_busy", 32'(o_busy), 0);
        chk("mrst_svalid", 32'(o_s_valid), 0);
        chk("mrst_mready", 32'(o_m_ready), 0);
        chk("mrst_mdata", o_m_data, 0);
        step();
        i_s_resp = 1'b0;
        do_txn(4'b1111, 0, 0, 32'h0000_00AA, 1'b0, 1'b0);
        chk("mrst_first", 32'(last), 0);

`ifdef BUS_GROUP_ARB_TIMEOUT_EN
        // No response: timeout on the 8th WAIT_RSP cycle.
        do_txn(4'b0100, 0, TO - 1, 32'h0, 1'b1, 1'b0);
        // Response on the expiry cycle wins.
        do_txn(4'b0001, 0, TO - 1, 32'h1357_2468, 1'b0, 1'b0);
`endif

        // Randomized traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] v;
            v = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) mdat[k] = $urandom;
            do_txn(v, $urandom_range(0, 3), $urandom_range(0, 4), $urandom,
                   1'b0, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
